// File: rtl/sram_pkg.sv
// Shared constants for the dual-port SRAM arbiter: state encoding, default
// widths and the read-return latency of the controller.
package sram_pkg;

    localparam int AW_DEF = 18;
    localparam int DW_DEF = 16;
    localparam int RD_LAT = 2;

    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_OWN0_ENC = 2'd1;
    localparam logic [1:0] ST_OWN1_ENC = 2'd2;
    localparam logic [1:0] ST_TURN_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_OWN0 = ST_OWN0_ENC,
        ST_OWN1 = ST_OWN1_ENC,
        ST_TURN = ST_TURN_ENC
    } state_t;

    function automatic state_t own_state(input logic port);
        return port ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/sram_rd_tag_pipe.sv
// Two-stage {valid, port} tag pipe that aligns each issued read with the
// controller's registered read data two cycles later.
module sram_rd_tag_pipe (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_vld,
    input  logic i_port,
    output logic o_rvalid0,
    output logic o_rvalid1
);

    logic r_vld_p0;
    logic r_vld_p1;
    logic r_port_p0;
    logic r_port_p1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_p0 <= 1'b0;
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p0 <= i_vld;
            r_vld_p1 <= r_vld_p0;
        end
    end

    // Port tags are only meaningful alongside a set valid, so they carry no reset.
    always_ff @(posedge i_clk) begin
        r_port_p0 <= i_port;
        r_port_p1 <= r_port_p0;
    end

    assign o_rvalid0 = r_vld_p1 && !r_port_p1;
    assign o_rvalid1 = r_vld_p1 &&  r_port_p1;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between two request ports,
// with bounded bursts, a turnaround cycle between owners and tagged read returns.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int BURST_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [DW-1:0] rdata,
    output logic          mem,
    output logic          rw,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] data_f2s,
    input  logic          ready,
    input  logic [DW-1:0] data_s2f_r
);

    localparam logic [3:0] BMAX = 4'(BURST_MAX);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_prio;
    logic          w_prio_nxt;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cnt_inc;
    logic          r_rw;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    logic          w_is_own;
    logic          w_own_port;
    logic          w_req_own;
    logic          w_req_oth;
    logic          w_issue;
    logic          w_enter;
    logic          w_sel_rw;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;

    assign w_is_own   = (r_state == ST_OWN0) || (r_state == ST_OWN1);
    assign w_own_port = (r_state == ST_OWN1);
    assign w_req_own  = w_own_port ? req1 : req0;
    assign w_req_oth  = w_own_port ? req0 : req1;
    assign w_issue    = w_is_own && w_req_own && ready;
    assign w_cnt_inc  = (r_cnt == BMAX) ? r_cnt : r_cnt + 4'd1;

    assign w_sel_rw    = w_own_port ? rw1    : rw0;
    assign w_sel_addr  = w_own_port ? addr1  : addr0;
    assign w_sel_wdata = w_own_port ? wdata1 : wdata0;

    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            ST_IDLE: begin
                if (req0 || req1)
                    w_state_nxt = own_state((r_prio ? req1 : req0) ? r_prio : !r_prio);
            end
            ST_OWN0, ST_OWN1: begin
                // A stalled controller freezes ownership entirely.
                if (ready) begin
                    if (!w_req_own) begin
                        w_state_nxt = w_req_oth ? ST_TURN : ST_IDLE;
                        w_prio_nxt  = !w_own_port;
                    end else if ((w_cnt_inc == BMAX) && w_req_oth) begin
                        w_state_nxt = ST_TURN;
                        w_prio_nxt  = !w_own_port;
                    end
                end
            end
            default: w_state_nxt = own_state(r_prio);
        endcase
    end

    assign w_enter = ((w_state_nxt == ST_OWN0) || (w_state_nxt == ST_OWN1)) &&
                     (w_state_nxt != r_state);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_cnt   <= 4'd0;
            r_rw    <= 1'b1;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
            if (w_enter)
                r_cnt <= 4'd0;
            else if (w_issue)
                r_cnt <= w_cnt_inc;
            if (w_issue) begin
                r_rw    <= w_sel_rw;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
        end
    end

    assign mem      = w_issue;
    assign ack0     = w_issue && !w_own_port;
    assign ack1     = w_issue &&  w_own_port;
    assign rw       = w_issue ? w_sel_rw    : r_rw;
    assign addr     = w_issue ? w_sel_addr  : r_addr;
    assign data_f2s = w_issue ? w_sel_wdata : r_wdata;
    assign rdata    = data_s2f_r;

    sram_rd_tag_pipe u_rd_tag_pipe (
        .i_clk     (clk),
        .i_rst     (reset),
        .i_vld     (w_issue && w_sel_rw),
        .i_port    (w_own_port),
        .o_rvalid0 (rvalid0),
        .o_rvalid1 (rvalid1)
    );

endmodule
